alu_rsv_station: RTL and testbench

- Reservation station and scheduler for the integer ALU in the Tomasulo core.
- Buffers decoded ALU and branch instructions from the dispatcher, tracks operand readiness by ROB tag, and snoops two result buses (ALU CDB, LSB CDB) to wake up waiting operands.
- Each cycle it selects at most one ready entry and drives the ALU's registered input bundle.
- Sits between decoder/dispatcher, ReorderBuffer flush and the ALU.

---
 rtl/alu_rsv_station_if.sv | 58 +++++
 rtl/alu_rsv_station.sv | 193 +++++++++++++++++++
 tb/tb_alu_rsv_station.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rsv_station_if.sv
// Bundle between the dispatcher / result buses and the ALU reservation station.
// master: dispatcher, CDB sources and ALU side; slave: the station itself.
interface alu_rsv_station_if #(
  parameter int ROB_ID_W = 4,
  parameter int DATA_W   = 32,
  parameter int OP_W     = 6
);
  // Dispatch port
  logic                issue_valid;
  logic [OP_W-1:0]     issue_op;
  logic [DATA_W-1:0]   issue_pc;
  logic [DATA_W-1:0]   issue_vj;
  logic [DATA_W-1:0]   issue_vk;
  logic                issue_qj_busy;
  logic                issue_qk_busy;
  logic [ROB_ID_W-1:0] issue_qj;
  logic [ROB_ID_W-1:0] issue_qk;
  logic [DATA_W-1:0]   issue_imm;
  logic [ROB_ID_W-1:0] issue_rob_id;
  logic                full;

  // Result broadcast buses
  logic                cdb_alu_valid;
  logic [ROB_ID_W-1:0] cdb_alu_rob_id;
  logic [DATA_W-1:0]   cdb_alu_value;
  logic                cdb_lsb_valid;
  logic [ROB_ID_W-1:0] cdb_lsb_rob_id;
  logic [DATA_W-1:0]   cdb_lsb_value;

  // Registered ALU input bundle
  logic                alu_valid;
  logic [OP_W-1:0]     alu_op;
  logic [DATA_W-1:0]   alu_pc;
  logic [DATA_W-1:0]   alu_rs1;
  logic [DATA_W-1:0]   alu_rs2;
  logic [DATA_W-1:0]   alu_imm;
  logic [ROB_ID_W-1:0] alu_rob_id;

  modport master (
    output issue_valid, issue_op, issue_pc, issue_vj, issue_vk,
           issue_qj_busy, issue_qk_busy, issue_qj, issue_qk,
           issue_imm, issue_rob_id,
           cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
           cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value,
    input  full,
           alu_valid, alu_op, alu_pc, alu_rs1, alu_rs2, alu_imm, alu_rob_id
  );

  modport slave (
    input  issue_valid, issue_op, issue_pc, issue_vj, issue_vk,
           issue_qj_busy, issue_qk_busy, issue_qj, issue_qk,
           issue_imm, issue_rob_id,
           cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
           cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value,
    output full,
           alu_valid, alu_op, alu_pc, alu_rs1, alu_rs2, alu_imm, alu_rob_id
  );
endinterface

// File: rtl/alu_rsv_station.sv
// Reservation station for the integer ALU: buffers dispatched instructions,
// wakes pending operands from the ALU and LSB result buses, and sends the
// lowest-index ready entry to the ALU each active cycle.
module alu_rsv_station #(
  parameter int ENTRIES  = 8,
  parameter int ROB_ID_W = 4,
  parameter int DATA_W   = 32,
  parameter int OP_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  alu_rsv_station_if.slave bus
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  // Slot occupancy and operand-pending flags
  logic [ENTRIES-1:0]  busy_q, busy_d;
  logic [ENTRIES-1:0]  qj_busy_q, qj_busy_d;
  logic [ENTRIES-1:0]  qk_busy_q, qk_busy_d;
  logic [ENTRIES-1:0]  ready;

  // Slot payload
  logic [OP_W-1:0]     op_q  [ENTRIES];
  logic [OP_W-1:0]     op_d  [ENTRIES];
  logic [DATA_W-1:0]   pc_q  [ENTRIES];
  logic [DATA_W-1:0]   pc_d  [ENTRIES];
  logic [DATA_W-1:0]   vj_q  [ENTRIES];
  logic [DATA_W-1:0]   vj_d  [ENTRIES];
  logic [DATA_W-1:0]   vk_q  [ENTRIES];
  logic [DATA_W-1:0]   vk_d  [ENTRIES];
  logic [DATA_W-1:0]   imm_q [ENTRIES];
  logic [DATA_W-1:0]   imm_d [ENTRIES];
  logic [ROB_ID_W-1:0] qj_q  [ENTRIES];
  logic [ROB_ID_W-1:0] qj_d  [ENTRIES];
  logic [ROB_ID_W-1:0] qk_q  [ENTRIES];
  logic [ROB_ID_W-1:0] qk_d  [ENTRIES];
  logic [ROB_ID_W-1:0] rob_q [ENTRIES];
  logic [ROB_ID_W-1:0] rob_d [ENTRIES];

  // Registered ALU bundle
  logic                alu_valid_q;
  logic [OP_W-1:0]     alu_op_q;
  logic [DATA_W-1:0]   alu_pc_q;
  logic [DATA_W-1:0]   alu_rs1_q;
  logic [DATA_W-1:0]   alu_rs2_q;
  logic [DATA_W-1:0]   alu_imm_q;
  logic [ROB_ID_W-1:0] alu_rob_id_q;

  // Allocation / selection
  logic                station_full;
  logic                issue_fire;
  logic [IDX_W-1:0]    free_idx;
  logic                sel_valid;
  logic [IDX_W-1:0]    sel_idx;

  // Local copies of the result buses
  logic                cdb_alu_valid;
  logic [ROB_ID_W-1:0] cdb_alu_rob_id;
  logic [DATA_W-1:0]   cdb_alu_value;
  logic                cdb_lsb_valid;
  logic [ROB_ID_W-1:0] cdb_lsb_rob_id;
  logic [DATA_W-1:0]   cdb_lsb_value;

  assign cdb_alu_valid  = bus.cdb_alu_valid;
  assign cdb_alu_rob_id = bus.cdb_alu_rob_id;
  assign cdb_alu_value  = bus.cdb_alu_value;
  assign cdb_lsb_valid  = bus.cdb_lsb_valid;
  assign cdb_lsb_rob_id = bus.cdb_lsb_rob_id;
  assign cdb_lsb_value  = bus.cdb_lsb_value;

  // full reflects the current state only, so a slot emptied by this edge's
  // dispatch is not reusable until the next edge.
  assign station_full = &busy_q;
  assign issue_fire   = bus.issue_valid && !station_full;

  // Lowest-index free slot for allocation
  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  // Lowest-index ready slot for dispatch (ready uses current state only,
  // so a wakeup is never dispatched on the edge that delivers it)
  always_comb begin
    sel_idx   = '0;
    sel_valid = |ready;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ready[i]) sel_idx = IDX_W'(i);
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic                alloc;
    logic                pend_j, pend_k;
    logic [ROB_ID_W-1:0] tag_j, tag_k;
    logic [DATA_W-1:0]   val_j, val_k;
    logic                hit_j_alu, hit_j_lsb, hit_k_alu, hit_k_lsb;

    assign alloc    = issue_fire && (free_idx == IDX_W'(gi));
    assign ready[gi] = busy_q[gi] && !qj_busy_q[gi] && !qk_busy_q[gi];

    // Operand source: the incoming instruction when allocating (so the
    // same-edge CDB bypass falls out of the common snoop), else stored state.
    assign pend_j = alloc ? bus.issue_qj_busy : qj_busy_q[gi];
    assign pend_k = alloc ? bus.issue_qk_busy : qk_busy_q[gi];
    assign tag_j  = alloc ? bus.issue_qj      : qj_q[gi];
    assign tag_k  = alloc ? bus.issue_qk      : qk_q[gi];
    assign val_j  = alloc ? bus.issue_vj      : vj_q[gi];
    assign val_k  = alloc ? bus.issue_vk      : vk_q[gi];

    assign hit_j_alu = pend_j && cdb_alu_valid && (tag_j == cdb_alu_rob_id);
    assign hit_j_lsb = pend_j && cdb_lsb_valid && (tag_j == cdb_lsb_rob_id);
    assign hit_k_alu = pend_k && cdb_alu_valid && (tag_k == cdb_alu_rob_id);
    assign hit_k_lsb = pend_k && cdb_lsb_valid && (tag_k == cdb_lsb_rob_id);

    // ALU bus takes precedence if both buses (illegally) carry the same tag
    assign vj_d[gi] = hit_j_alu ? cdb_alu_value : (hit_j_lsb ? cdb_lsb_value : val_j);
    assign vk_d[gi] = hit_k_alu ? cdb_alu_value : (hit_k_lsb ? cdb_lsb_value : val_k);
    assign qj_busy_d[gi] = pend_j && !hit_j_alu && !hit_j_lsb;
    assign qk_busy_d[gi] = pend_k && !hit_k_alu && !hit_k_lsb;
    assign qj_d[gi]  = tag_j;
    assign qk_d[gi]  = tag_k;

    assign op_d[gi]  = alloc ? bus.issue_op     : op_q[gi];
    assign pc_d[gi]  = alloc ? bus.issue_pc     : pc_q[gi];
    assign imm_d[gi] = alloc ? bus.issue_imm    : imm_q[gi];
    assign rob_d[gi] = alloc ? bus.issue_rob_id : rob_q[gi];

    // Allocation only targets an empty slot, dispatch only a busy one
    assign busy_d[gi] = alloc || (busy_q[gi] && !(sel_valid && (sel_idx == IDX_W'(gi))));
  end

  // Control state and ALU bundle: reset > freeze > flush > normal operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q       <= '0;
      alu_valid_q  <= 1'b0;
      alu_op_q     <= '0;
      alu_pc_q     <= '0;
      alu_rs1_q    <= '0;
      alu_rs2_q    <= '0;
      alu_imm_q    <= '0;
      alu_rob_id_q <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy_q      <= '0;
        alu_valid_q <= 1'b0;
      end else begin
        busy_q      <= busy_d;
        alu_valid_q <= sel_valid;
        if (sel_valid) begin
          alu_op_q     <= op_q[sel_idx];
          alu_pc_q     <= pc_q[sel_idx];
          alu_rs1_q    <= vj_q[sel_idx];
          alu_rs2_q    <= vk_q[sel_idx];
          alu_imm_q    <= imm_q[sel_idx];
          alu_rob_id_q <= rob_q[sel_idx];
        end
      end
    end
  end

  // Slot payload; meaningful only while the matching busy bit is set
  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      qj_busy_q <= qj_busy_d;
      qk_busy_q <= qk_busy_d;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]  <= op_d[i];
        pc_q[i]  <= pc_d[i];
        vj_q[i]  <= vj_d[i];
        vk_q[i]  <= vk_d[i];
        imm_q[i] <= imm_d[i];
        qj_q[i]  <= qj_d[i];
        qk_q[i]  <= qk_d[i];
        rob_q[i] <= rob_d[i];
      end
    end
  end

  assign bus.full       = station_full;
  assign bus.alu_valid  = alu_valid_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_pc     = alu_pc_q;
  assign bus.alu_rs1    = alu_rs1_q;
  assign bus.alu_rs2    = alu_rs2_q;
  assign bus.alu_imm    = alu_imm_q;
  assign bus.alu_rob_id = alu_rob_id_q;
endmodule

// File: tb/tb_alu_rsv_station.sv
// Bench for alu_rsv_station: expected ALU bundles are queued as stimulus is
// driven and checked as the station dispatches; scenario tasks check timing.
`timescale 1ns/1ps
module tb_alu_rsv_station;
  localparam int ENTRIES  = 8;
  localparam int ROB_ID_W = 4;
  localparam int DATA_W   = 32;
  localparam int OP_W     = 6;

  typedef struct {
    logic [OP_W-1:0]     op;
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   rs1;
    logic [DATA_W-1:0]   rs2;
    logic [DATA_W-1:0]   imm;
    logic [ROB_ID_W-1:0] rob;
  } exp_t;

  logic clk, rst, rdy, flush;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic edge_active = 1'b0;
  exp_t sb[$];

  alu_rsv_station_if #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  alu_rsv_station #(.ENTRIES(ENTRIES), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An edge only produces a new bundle when the block was live on it
  always @(posedge clk) edge_active <= rdy && !rst;

  // Scoreboard: every fresh dispatch must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && edge_active && bus.alu_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_dispatch got rob=%0d op=%0d rs1=%0h required no dispatch",
                 bus.alu_rob_id, bus.alu_op, bus.alu_rs1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.alu_op !== e.op || bus.alu_pc !== e.pc || bus.alu_rs1 !== e.rs1 ||
            bus.alu_rs2 !== e.rs2 || bus.alu_imm !== e.imm || bus.alu_rob_id !== e.rob) begin
          n_fail++;
          $display("FAIL dispatch_bundle got op=%0d pc=%0h rs1=%0h rs2=%0h imm=%0h rob=%0d required op=%0d pc=%0h rs1=%0h rs2=%0h imm=%0h rob=%0d",
                   bus.alu_op, bus.alu_pc, bus.alu_rs1, bus.alu_rs2, bus.alu_imm, bus.alu_rob_id,
                   e.op, e.pc, e.rs1, e.rs2, e.imm, e.rob);
        end else begin
          $display("dispatch rob=%0d op=%0d rs1=%0h rs2=%0h ok", e.rob, e.op, e.rs1, e.rs2);
        end
      end
    end
  end

  function automatic exp_t mk(input int op, input int pc, input int rs1, input int rs2,
                              input int imm, input int rob);
    exp_t e;
    e.op  = OP_W'(op);
    e.pc  = DATA_W'(pc);
    e.rs1 = DATA_W'(rs1);
    e.rs2 = DATA_W'(rs2);
    e.imm = DATA_W'(imm);
    e.rob = ROB_ID_W'(rob);
    return e;
  endfunction

  // Expected bundle of fill-test slot i once its rs1 is woken with value v
  function automatic exp_t slot_exp(input int i, input int v);
    return mk(10 + i, 32'h1000 + 4 * i, v, 32'h100 + i, i, i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.issue_valid   = 1'b0;
    bus.cdb_alu_valid = 1'b0;
    bus.cdb_lsb_valid = 1'b0;
    flush             = 1'b0;
  endtask

  task automatic drive_issue(input int op, input int pc, input int vj, input int vk,
                             input int qjb, input int qkb, input int qj, input int qk,
                             input int imm, input int rob);
    bus.issue_valid   = 1'b1;
    bus.issue_op      = OP_W'(op);
    bus.issue_pc      = DATA_W'(pc);
    bus.issue_vj      = DATA_W'(vj);
    bus.issue_vk      = DATA_W'(vk);
    bus.issue_qj_busy = (qjb != 0);
    bus.issue_qk_busy = (qkb != 0);
    bus.issue_qj      = ROB_ID_W'(qj);
    bus.issue_qk      = ROB_ID_W'(qk);
    bus.issue_imm     = DATA_W'(imm);
    bus.issue_rob_id  = ROB_ID_W'(rob);
  endtask

  task automatic drive_cdb_alu(input int tag, input int val);
    bus.cdb_alu_valid  = 1'b1;
    bus.cdb_alu_rob_id = ROB_ID_W'(tag);
    bus.cdb_alu_value  = DATA_W'(val);
  endtask

  task automatic drive_cdb_lsb(input int tag, input int val);
    bus.cdb_lsb_valid  = 1'b1;
    bus.cdb_lsb_rob_id = ROB_ID_W'(tag);
    bus.cdb_lsb_value  = DATA_W'(val);
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1;
    clear_inputs();
    drive_issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.issue_valid = 1'b0;
    drive_cdb_alu(0, 0); drive_cdb_lsb(0, 0);
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_alu_valid got %0b required 0", bus.alu_valid); end
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b required 0", bus.full); end
    n_checks++; if (bus.alu_rs1 !== '0 || bus.alu_op !== '0 || bus.alu_rob_id !== '0) begin
      n_fail++; $display("FAIL reset_data got rs1=%0h op=%0d rob=%0d required 0", bus.alu_rs1, bus.alu_op, bus.alu_rob_id); end
    $display("reset done");
    rst = 1'b0;
  endtask

  task automatic test_basic();
    drive_issue(1, 32'h40, 5, 7, 0, 0, 0, 0, 0, 3);
    sb.push_back(mk(1, 32'h40, 5, 7, 0, 3));
    step(); clear_inputs();
    n_checks++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL basic_edge1 alu_valid got %0b required 0", bus.alu_valid); end
    step();
    n_checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rob_id !== 4'd3) begin
      n_fail++; $display("FAIL basic_edge2 alu_valid=%0b rob=%0d required 1/3", bus.alu_valid, bus.alu_rob_id); end
    step();
    n_checks++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL basic_edge3 alu_valid got %0b required 0", bus.alu_valid); end
  endtask

  task automatic test_wakeup();
    drive_issue(2, 32'h44, 32'hDEAD, 9, 1, 0, 1, 0, 0, 2);
    step(); clear_inputs();
    step();
    n_checks++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL wakeup_pending alu_valid got %0b required 0", bus.alu_valid); end
    drive_cdb_lsb(1, 32'h10);
    sb.push_back(mk(2, 32'h44, 32'h10, 9, 0, 2));
    step(); clear_inputs();
    n_checks++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL wakeup_same_edge alu_valid got %0b required 0", bus.alu_valid); end
    step();
    n_checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rs1 !== 32'h10) begin
      n_fail++; $display("FAIL wakeup_dispatch alu_valid=%0b rs1=%0h required 1/10", bus.alu_valid, bus.alu_rs1); end
  endtask

  task automatic test_bypass();
    drive_issue(3, 32'h48, 1, 32'h5A5A, 0, 1, 0, 6, 0, 4);
    drive_cdb_alu(6, 32'hAB);
    sb.push_back(mk(3, 32'h48, 1, 32'hAB, 0, 4));
    step(); clear_inputs();
    n_checks++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_edge alu_valid got %0b required 0", bus.alu_valid); end
    step();
    n_checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rs2 !== 32'hAB) begin
      n_fail++; $display("FAIL bypass_dispatch alu_valid=%0b rs2=%0h required 1/ab", bus.alu_valid, bus.alu_rs2); end
  endtask

  // Slots 0..7 wait on tags 8..15 respectively
  task automatic test_full();
    for (int i = 0; i < ENTRIES; i++) begin
      drive_issue(10 + i, 32'h1000 + 4 * i, 0, 32'h100 + i, 1, 0, 8 + i, 0, i, i);
      step(); clear_inputs();
      if (i < ENTRIES - 1) begin
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL full_early slot=%0d got %0b required 0", i, bus.full); end
      end
    end
    n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_set got %0b required 1", bus.full); end
    drive_issue(20, 32'h2000, 1, 2, 0, 0, 0, 0, 0, 15);
    step(); clear_inputs();
    n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_ninth got %0b required 1", bus.full); end
    step();
    n_checks++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL full_ninth_ignored alu_valid got %0b required 0", bus.alu_valid); end
    drive_cdb_alu(13, 32'h55);
    sb.push_back(slot_exp(5, 32'h55));
    step(); clear_inputs();
    n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_before_dispatch got %0b required 1", bus.full); end
    step();
    n_checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rob_id !== 4'd5 || bus.full !== 1'b0) begin
      n_fail++; $display("FAIL full_slot5 alu_valid=%0b rob=%0d full=%0b required 1/5/0", bus.alu_valid, bus.alu_rob_id, bus.full); end
  endtask

  task automatic test_priority();
    drive_cdb_alu(14, 32'h66);
    drive_cdb_lsb(10, 32'h22);
    sb.push_back(slot_exp(2, 32'h22));
    sb.push_back(slot_exp(6, 32'h66));
    step(); clear_inputs();
    n_checks++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL prio_wake_edge alu_valid got %0b required 0", bus.alu_valid); end
    step();
    n_checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rob_id !== 4'd2) begin
      n_fail++; $display("FAIL prio_first alu_valid=%0b rob=%0d required 1/2", bus.alu_valid, bus.alu_rob_id); end
    step();
    n_checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rob_id !== 4'd6) begin
      n_fail++; $display("FAIL prio_second alu_valid=%0b rob=%0d required 1/6", bus.alu_valid, bus.alu_rob_id); end
  endtask

  task automatic test_rdy_hold();
    drive_cdb_alu(15, 32'h77);
    sb.push_back(slot_exp(7, 32'h77));
    step(); clear_inputs();
    step();
    n_checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rob_id !== 4'd7) begin
      n_fail++; $display("FAIL hold_pre alu_valid=%0b rob=%0d required 1/7", bus.alu_valid, bus.alu_rob_id); end
    rdy = 1'b0;
    drive_cdb_alu(8, 32'h99);
    drive_issue(21, 32'h3000, 3, 4, 0, 0, 0, 0, 0, 14);
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rob_id !== 4'd7 || bus.alu_rs1 !== 32'h77 || bus.full !== 1'b0) begin
        n_fail++; $display("FAIL hold_frozen cycle=%0d alu_valid=%0b rob=%0d rs1=%0h full=%0b required 1/7/77/0",
                           c, bus.alu_valid, bus.alu_rob_id, bus.alu_rs1, bus.full); end
    end
    rdy = 1'b1;
    clear_inputs();
    step();
    n_checks++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release alu_valid got %0b required 0", bus.alu_valid); end
    step();
    n_checks++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL hold_no_ghost alu_valid got %0b required 0", bus.alu_valid); end
  endtask

  // Slots 0,1,3,4 (tags 8,9,11,12) are still pending here
  task automatic test_flush();
    flush = 1'b1;
    drive_issue(22, 32'h4000, 1, 1, 0, 0, 0, 0, 0, 13);
    drive_cdb_alu(9, 32'h11);
    step(); clear_inputs();
    n_checks++; if (bus.full !== 1'b0 || bus.alu_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear full=%0b alu_valid=%0b required 0/0", bus.full, bus.alu_valid); end
    drive_cdb_alu(8, 1); drive_cdb_lsb(9, 2);
    step(); clear_inputs();
    drive_cdb_alu(11, 3); drive_cdb_lsb(12, 4);
    n_checks++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard_issue alu_valid got %0b required 0", bus.alu_valid); end
    step(); clear_inputs();
    step();
    n_checks++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL flush_entries_gone alu_valid got %0b required 0", bus.alu_valid); end
    step();
    n_checks++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL flush_entries_gone2 alu_valid got %0b required 0", bus.alu_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive_issue(30 + i, 32'h5000 + 4 * i, 16 * i + 1, 32'h20 + i, 0, 0, 0, 0, i, i);
      sb.push_back(mk(30 + i, 32'h5000 + 4 * i, 16 * i + 1, 32'h20 + i, i, i));
      step();
      n_checks++; if (bus.alu_valid !== (i != 0)) begin
        n_fail++; $display("FAIL b2b_issue%0d alu_valid got %0b required %0b", i, bus.alu_valid, (i != 0)); end
    end
    clear_inputs();
    step();
    n_checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rob_id !== 4'd2) begin
      n_fail++; $display("FAIL b2b_last alu_valid=%0b rob=%0d required 1/2", bus.alu_valid, bus.alu_rob_id); end
    step();
    n_checks++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain alu_valid got %0b required 0", bus.alu_valid); end
  endtask

  task automatic test_async_reset();
    drive_issue(40, 32'h6000, 32'h31, 32'h32, 0, 0, 0, 0, 0, 9);
    step(); clear_inputs();
    drive_issue(41, 32'h6004, 1, 2, 1, 0, 3, 0, 0, 10);
    step(); clear_inputs();
    n_checks++; if (bus.alu_valid !== 1'b1 || bus.alu_rob_id !== 4'd9) begin
      n_fail++; $display("FAIL arst_pre alu_valid=%0b rob=%0d required 1/9", bus.alu_valid, bus.alu_rob_id); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.alu_valid !== 1'b0 || bus.alu_rs1 !== '0 || bus.full !== 1'b0) begin
      n_fail++; $display("FAIL arst_immediate alu_valid=%0b rs1=%0h full=%0b required 0/0/0", bus.alu_valid, bus.alu_rs1, bus.full); end
    step();
    rst = 1'b0;
    drive_cdb_alu(3, 5);
    step(); clear_inputs();
    step();
    n_checks++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL arst_entries_gone alu_valid got %0b required 0", bus.alu_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full();
    test_priority();
    test_rdy_hold();
    test_flush();
    test_back_to_back();
    test_async_reset();
    step();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drained got %0d pending required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
